// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
package imem_arb_pkg;

  localparam int unsigned DEFAULT_DEPTH = 64;
  localparam int unsigned DEFAULT_AW    = 6;

  // MOV R0,R0: harmless filler fetched for out-of-range PCs and outside RUN.
  localparam logic [31:0] NOP_WORD = 32'hE1A00000;

  typedef enum logic [1:0] {
    StHold = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2,
    StRun  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction RAM: synchronous write, combinational read.
module imem_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wd,
  output logic [31:0]   o_rd
);

  logic [31:0] r_mem [DEPTH];

  // Single write port; contents are never cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wd;
    end
  end

  assign o_rd = r_mem[i_addr];

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-RAM address port between the program loader,
// the fetch stage and a debug read port, and sequences the CPU out of reset
// once a program has been loaded.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AW       = DEFAULT_AW,
  parameter logic [31:0] NOP_WORD = imem_arb_pkg::NOP_WORD
) (
  input  logic          clk,
  input  logic          reset,
  // Program loader
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic [AW:0]   ld_count,
  // Pipeline
  output logic          cpu_reset,
  input  logic [31:0]   pcf,
  input  logic          stallf,
  output logic [31:0]   instrf,
  // Debug read port
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_ack,
  output logic [31:0]   dbg_rdata,
  // RAM port
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  arb_state_e    r_state, w_state_next;
  logic [AW-1:0] r_ld_addr, w_ld_addr_next;
  logic [AW:0]   r_ld_count, w_ld_count_next;
  logic          r_dbg_ack;
  logic [31:0]   r_dbg_rdata;
  logic [31:0]   r_held_instr;

  logic          w_ld_write;
  logic          w_fetch_own;
  logic          w_dbg_grant;
  logic          w_pc_oob;
  logic [31:0]   w_instr;
  logic          w_unused_pcf;

  // Fetch is word aligned; the byte offset is deliberately dropped.
  assign w_unused_pcf = ^pcf[1:0];

  assign w_pc_oob    = |pcf[31:AW+2];
  assign w_fetch_own = (r_state == StRun) && !stallf;
  // A restart cycle discards the word on the bus.
  assign w_ld_write  = (r_state == StLoad) && ld_valid && !ld_start;

  // Debug only gets the port when neither loader nor fetch needs it, and never
  // on its own ack cycle so a held request is not served twice.
  assign w_dbg_grant = dbg_req && !r_dbg_ack &&
                       (((r_state == StRun) && stallf) ||
                        (r_state == StHold) || (r_state == StDone) ||
                        ((r_state == StLoad) && !ld_valid));

  // Next-state and loader address/count sequencing.
  always_comb begin
    w_state_next    = r_state;
    w_ld_addr_next  = r_ld_addr;
    w_ld_count_next = r_ld_count;
    unique case (r_state)
      StHold, StRun: begin
        if (ld_start) begin
          w_state_next    = StLoad;
          w_ld_addr_next  = '0;
          w_ld_count_next = '0;
        end
      end
      StLoad: begin
        if (ld_start) begin
          w_ld_addr_next  = '0;
          w_ld_count_next = '0;
        end else if (ld_valid) begin
          w_ld_addr_next  = r_ld_addr + 1'b1;
          w_ld_count_next = r_ld_count + 1'b1;
          // Stop at the last RAM word so the address never wraps onto word 0.
          if (ld_last || (r_ld_addr == AW'(DEPTH - 1))) begin
            w_state_next = StDone;
          end
        end
      end
      StDone: begin
        w_state_next = StRun;
      end
      default: begin
        w_state_next = StHold;
      end
    endcase
  end

  // RAM port mux (loader > fetch > debug) and instruction selection.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = pcf[AW+1:2];
    mem_wd   = ld_data;
    w_instr  = NOP_WORD;
    if (w_ld_write) begin
      mem_we   = 1'b1;
      mem_addr = r_ld_addr;
    end else if (w_dbg_grant) begin
      mem_addr = dbg_addr;
    end
    if (r_state == StRun) begin
      // PC is held while debug owns the port, so the last fetched word is
      // still the right one.
      if (w_dbg_grant) begin
        w_instr = r_held_instr;
      end else begin
        w_instr = w_pc_oob ? NOP_WORD : mem_rd;
      end
    end
  end

  // FSM and loader state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StHold;
      r_ld_addr  <= '0;
      r_ld_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ld_addr  <= w_ld_addr_next;
      r_ld_count <= w_ld_count_next;
    end
  end

  // Debug response and held fetch word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dbg_ack    <= 1'b0;
      r_dbg_rdata  <= '0;
      r_held_instr <= NOP_WORD;
    end else begin
      r_dbg_ack <= w_dbg_grant;
      if (w_dbg_grant) begin
        r_dbg_rdata <= mem_rd;
      end
      if (w_fetch_own) begin
        r_held_instr <= w_instr;
      end
    end
  end

  assign ld_ready  = (r_state == StLoad) && !ld_start;
  assign ld_count  = r_ld_count;
  assign cpu_reset = (r_state != StRun);
  assign instrf    = w_instr;
  assign dbg_ack   = r_dbg_ack;
  assign dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter with the RAM wired beside it.
module tb_imem_port_arbiter;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        reset, ld_start, ld_valid, ld_last, stallf, dbg_req;
  logic [31:0] ld_data, pcf;
  logic [5:0]  dbg_addr;
  logic        ld_ready, cpu_reset, dbg_ack, mem_we;
  logic [6:0]  ld_count;
  logic [31:0] instrf, dbg_rdata, mem_wd, mem_rd;
  logic [5:0]  mem_addr;

  int total = 0;
  int bad = 0;

  // Reference model of RAM contents as the loader protocol should leave them.
  logic [31:0] model_ram [64];
  bit          model_valid [64];
  logic [31:0] ld_q [$];

  always #5 clk = ~clk;

  imem_port_arbiter #(.DEPTH(64), .AW(6), .NOP_WORD(32'hE1A00000)) dut (
    .clk(clk), .reset(reset),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_count(ld_count),
    .cpu_reset(cpu_reset), .pcf(pcf), .stallf(stallf), .instrf(instrf),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  imem_ram #(.DEPTH(64), .AW(6)) u_ram (
    .i_clk(clk), .i_we(mem_we), .i_addr(mem_addr), .i_wd(mem_wd), .o_rd(mem_rd)
  );

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Words of a load land at addresses 0.. and nothing beyond the RAM.
  task automatic model_load();
    for (int i = 0; i < ld_q.size() && i < 64; i++) begin
      model_ram[i]   = ld_q[i];
      model_valid[i] = 1'b1;
    end
  endtask

  // Pulse ld_start then stream ld_q; returns the number of accepted beats.
  task automatic load_words(input bit use_last, input int gap_pct, output int acc);
    acc = 0;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < ld_q.size(); i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        ld_valid = 1'b0;
        step();
      end
      ld_valid = 1'b1;
      ld_data  = ld_q[i];
      ld_last  = use_last && (i == ld_q.size() - 1);
      #2;
      if (ld_ready && mem_we) acc++;
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Cycles until cpu_reset drops, bounded.
  task automatic wait_run(output int cycles);
    cycles = 0;
    while (cpu_reset && cycles < 10) begin
      step();
      cycles++;
    end
  endtask

  // Issue a debug read; lat is cycles from request to ack (20 = timed out).
  task automatic dbg_read(input logic [5:0] a, output logic [31:0] data, output int lat);
    dbg_req  = 1'b1;
    dbg_addr = a;
    lat      = 0;
    data     = 32'hxxxxxxxx;
    while (lat < 20) begin
      step();
      lat++;
      if (dbg_ack) begin
        data = dbg_rdata;
        break;
      end
    end
    dbg_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    #2;
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
    total++; if (ld_count !== 7'd0) begin bad++; $display("FAIL reset_ld_count got=%0d exp=0", ld_count); end
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL reset_dbg_ack got=%b exp=0", dbg_ack); end
    total++; if (dbg_rdata !== 32'd0) begin bad++; $display("FAIL reset_dbg_rdata got=%h exp=0", dbg_rdata); end
    total++; if (instrf !== NOP) begin bad++; $display("FAIL reset_instrf got=%h exp=%h", instrf, NOP); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    reset = 1'b0;
  endtask

  task automatic test_boot_load();
    int acc, cyc;
    ld_q = {32'hE3A00005, 32'hE2801001, 32'hE0812000};
    load_words(1'b1, 0, acc);
    model_load();
    total++; if (acc != 3) begin bad++; $display("FAIL boot_accepts got=%0d exp=3", acc); end
    total++; if (ld_count !== 7'd3) begin bad++; $display("FAIL boot_ld_count got=%0d exp=3", ld_count); end
    total++; if (cpu_reset !== 1'b1 || ld_ready !== 1'b0) begin bad++; $display("FAIL boot_done_outputs got=%b%b exp=10", cpu_reset, ld_ready); end
    wait_run(cyc);
    total++; if (cyc != 1) begin bad++; $display("FAIL boot_release_delay got=%0d exp=1", cyc); end
    pcf = 32'h4;
    stallf = 1'b0;
    #2;
    total++; if (instrf !== 32'hE2801001) begin bad++; $display("FAIL boot_fetch got=%h exp=E2801001", instrf); end
    step();
  endtask

  task automatic test_debug_stall();
    int acks;
    pcf = 32'h8;
    stallf = 1'b0;
    step();
    stallf = 1'b1;
    dbg_req = 1'b1;
    dbg_addr = 6'd1;
    #2;
    total++; if (instrf !== model_ram[2]) begin bad++; $display("FAIL dbg_instr_grant got=%h exp=%h", instrf, model_ram[2]); end
    step();
    #2;
    total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL dbg_ack_pulse got=%b exp=1", dbg_ack); end
    total++; if (dbg_rdata !== model_ram[1]) begin bad++; $display("FAIL dbg_rdata got=%h exp=%h", dbg_rdata, model_ram[1]); end
    total++; if (instrf !== model_ram[2]) begin bad++; $display("FAIL dbg_instr_ack got=%h exp=%h", instrf, model_ram[2]); end
    dbg_req = 1'b0;
    step();
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL dbg_ack_single got=%b exp=0", dbg_ack); end
    // Fetch has priority when not stalled: a held request starves.
    stallf = 1'b0;
    dbg_req = 1'b1;
    dbg_addr = 6'd0;
    acks = 0;
    repeat (10) begin
      step();
      if (dbg_ack) acks++;
    end
    total++; if (acks != 0) begin bad++; $display("FAIL dbg_starve got=%0d exp=0", acks); end
    dbg_req = 1'b0;
    step();
  endtask

  task automatic test_full_memory();
    int acc, first_off;
    logic rst64, rst65;
    logic [5:0] addr63;
    acc = 0;
    first_off = -1;
    rst64 = 1'bx;
    rst65 = 1'bx;
    addr63 = 6'h00;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 70; i++) begin
      ld_valid = 1'b1;
      ld_data = $urandom;
      #2;
      if (ld_ready && mem_we) acc++;
      else if (first_off < 0) first_off = i;
      if (i == 63) addr63 = mem_addr;
      if (i == 64) rst64 = cpu_reset;
      if (i == 65) rst65 = cpu_reset;
      if (i < 64) begin
        model_ram[i] = ld_data;
        model_valid[i] = 1'b1;
      end
      step();
    end
    ld_valid = 1'b0;
    total++; if (acc != 64) begin bad++; $display("FAIL full_accepts got=%0d exp=64", acc); end
    total++; if (first_off != 64) begin bad++; $display("FAIL full_ready_drop got=%0d exp=64", first_off); end
    total++; if (addr63 !== 6'd63) begin bad++; $display("FAIL full_last_addr got=%0d exp=63", addr63); end
    total++; if (rst64 !== 1'b1 || rst65 !== 1'b0) begin bad++; $display("FAIL full_done_run got=%b%b exp=10", rst64, rst65); end
    total++; if (ld_count !== 7'd64) begin bad++; $display("FAIL full_ld_count got=%0d exp=64", ld_count); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL full_ready_after got=%b exp=0", ld_ready); end
  endtask

  task automatic test_oob_fetch();
    stallf = 1'b0;
    pcf = 32'h100;
    #2;
    total++; if (instrf !== NOP) begin bad++; $display("FAIL oob_0x100 got=%h exp=%h", instrf, NOP); end
    step();
    pcf = 32'h0FC;
    #2;
    total++; if (instrf !== model_ram[63]) begin bad++; $display("FAIL oob_0xfc got=%h exp=%h", instrf, model_ram[63]); end
    step();
    pcf = 32'h8000_0000;
    #2;
    total++; if (instrf !== NOP) begin bad++; $display("FAIL oob_high got=%h exp=%h", instrf, NOP); end
    step();
    pcf = 32'h0FF;
    #2;
    total++; if (instrf !== model_ram[63]) begin bad++; $display("FAIL oob_byte_off got=%h exp=%h", instrf, model_ram[63]); end
    step();
  endtask

  task automatic test_reload();
    int cyc;
    ld_start = 1'b1;
    #2;
    total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL reload_before got=%b exp=0", cpu_reset); end
    step();
    ld_start = 1'b0;
    #2;
    total++; if (cpu_reset !== 1'b1 || instrf !== NOP) begin bad++; $display("FAIL reload_enter got=%b/%h exp=1/%h", cpu_reset, instrf, NOP); end
    ld_valid = 1'b1;
    ld_data = 32'hEAFFFFFE;
    ld_last = 1'b1;
    #1;
    total++; if (mem_we !== 1'b1 || mem_addr !== 6'd0) begin bad++; $display("FAIL reload_write got=%b/%0d exp=1/0", mem_we, mem_addr); end
    step();
    ld_valid = 1'b0;
    ld_last = 1'b0;
    model_ram[0] = 32'hEAFFFFFE;
    wait_run(cyc);
    total++; if (cyc != 1) begin bad++; $display("FAIL reload_release got=%0d exp=1", cyc); end
    total++; if (ld_count !== 7'd1) begin bad++; $display("FAIL reload_count got=%0d exp=1", ld_count); end
    pcf = 32'h0;
    #2;
    total++; if (instrf !== 32'hEAFFFFFE) begin bad++; $display("FAIL reload_word0 got=%h exp=EAFFFFFE", instrf); end
    step();
    pcf = 32'h4;
    #2;
    total++; if (instrf !== model_ram[1]) begin bad++; $display("FAIL reload_word1 got=%h exp=%h", instrf, model_ram[1]); end
    step();
  endtask

  task automatic test_reset_mid_load();
    int acc, lat;
    logic [31:0] d;
    ld_q = {};
    ld_q.push_back($urandom);
    ld_q.push_back($urandom);
    load_words(1'b0, 0, acc);
    model_load();
    // A debug grant on the reset cycle must not produce an ack.
    dbg_req = 1'b1;
    dbg_addr = 6'd0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    dbg_req = 1'b0;
    #2;
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL midrst_ack_drop got=%b exp=0", dbg_ack); end
    total++; if (ld_count !== 7'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", ld_count); end
    total++; if (cpu_reset !== 1'b1 || ld_ready !== 1'b0) begin bad++; $display("FAIL midrst_outputs got=%b%b exp=10", cpu_reset, ld_ready); end
    ld_valid = 1'b1;
    ld_data = 32'h12345678;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL midrst_hold_nowrite got=%b exp=0", mem_we); end
    step();
    ld_valid = 1'b0;
    step();
    dbg_read(6'd0, d, lat);
    total++; if (lat != 1 || d !== model_ram[0]) begin bad++; $display("FAIL midrst_ram0 got=%h/%0d exp=%h/1", d, lat, model_ram[0]); end
    step();
    dbg_read(6'd1, d, lat);
    total++; if (lat != 1 || d !== model_ram[1]) begin bad++; $display("FAIL midrst_ram1 got=%h/%0d exp=%h/1", d, lat, model_ram[1]); end
    step();
  endtask

  task automatic test_random();
    int n, acc, cyc, lat;
    logic [5:0] a;
    logic [31:0] d, exp;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 12);
      ld_q = {};
      for (int i = 0; i < n; i++) ld_q.push_back($urandom);
      load_words(1'b1, 30, acc);
      model_load();
      total++; if (acc != n) begin bad++; $display("FAIL rnd_accepts it=%0d got=%0d exp=%0d", it, acc, n); end
      wait_run(cyc);
      total++; if (cyc != 1) begin bad++; $display("FAIL rnd_release it=%0d got=%0d exp=1", it, cyc); end
      total++; if (ld_count !== 7'(n)) begin bad++; $display("FAIL rnd_count it=%0d got=%0d exp=%0d", it, ld_count, n); end
      stallf = 1'b0;
      for (int f = 0; f < 6; f++) begin
        if ($urandom_range(3) == 0) begin
          pcf = $urandom;
          if (pcf[31:8] == 24'd0) pcf[31] = 1'b1;
          exp = NOP;
        end else begin
          a = 6'($urandom_range(63));
          if (!model_valid[a]) a = 6'(int'(a) % n);
          pcf = {24'd0, a, 2'($urandom_range(3))};
          exp = model_ram[a];
        end
        #2;
        total++; if (instrf !== exp) begin bad++; $display("FAIL rnd_fetch pcf=%h got=%h exp=%h", pcf, instrf, exp); end
        step();
      end
      stallf = 1'b1;
      a = 6'($urandom_range(n - 1));
      dbg_read(a, d, lat);
      total++; if (lat != 1 || d !== model_ram[a]) begin bad++; $display("FAIL rnd_dbg addr=%0d got=%h/%0d exp=%h/1", a, d, lat, model_ram[a]); end
      stallf = 1'b0;
      step();
    end
  endtask

  initial begin
    reset = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    pcf = '0; stallf = 1'b0; dbg_req = 1'b0; dbg_addr = '0;
    for (int i = 0; i < 64; i++) begin
      model_ram[i] = '0;
      model_valid[i] = 1'b0;
    end
    test_reset();
    test_boot_load();
    test_debug_stall();
    test_full_memory();
    test_oob_fetch();
    test_reload();
    test_reset_mid_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
